// File: rtl/proc_run_ctrl.sv
// ============================================================================
// Module   : proc_run_ctrl
// Purpose  : Run controller for singleCycleProc. It sequences the processor
//            reset, counts RUN cycles and ends the run on halt, on timeout, or
//            on a PC stall when RUN_CTRL_STALL_DET_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_run_ctrl #(
   parameter int RST_CYCLES   = 1,
   parameter int MAX_CYCLES   = 7,
   parameter int CNT_W        = 16,
   parameter int PC_W         = 32,
   parameter int STALL_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt,
   input  logic [PC_W-1:0]  pc,
   output logic             proc_rst,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic             stalled,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RESET = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [7:0]       c_rst_load = 8'(RST_CYCLES);
   localparam logic [CNT_W:0]   c_max      = (CNT_W+1)'(MAX_CYCLES);
   localparam logic [CNT_W-1:0] c_ones     = '1;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_rst_cnt, w_rst_cnt_nxt;
   logic [CNT_W-1:0] r_cycle_count, w_cnt_nxt, w_cnt_inc;
   logic             r_proc_rst, r_running, r_done, r_timeout, r_stalled;
   logic             w_timeout_nxt, w_stalled_nxt;
   logic             w_limit, w_stall;

`ifdef RUN_CTRL_STALL_DET_EN
   localparam int SW = $clog2(STALL_CYCLES + 1);

   logic [PC_W-1:0] r_pc_prev;
   logic [SW-1:0]   r_stall_cnt, w_stall_cnt_nxt;

   // Counter holds how many consecutive RUN cycles pc has kept its value,
   // the first cycle at a new value counting as one.
   always_comb begin
      w_stall_cnt_nxt = SW'(1);
      if ((pc == r_pc_prev) && (r_stall_cnt != '0))
         w_stall_cnt_nxt = SW'(r_stall_cnt + 1'b1);
      w_stall = (r_state == S_RUN) && (w_stall_cnt_nxt == SW'(STALL_CYCLES));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc_prev   <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_pc_prev   <= pc;
         r_stall_cnt <= (r_state == S_RUN) ? w_stall_cnt_nxt : '0;
      end
   end
`else
   logic w_unused_pc;
   assign w_unused_pc = ^pc;
   assign w_stall     = 1'b0;
`endif

   assign w_cnt_inc = (r_cycle_count == c_ones) ? r_cycle_count : r_cycle_count + 1'b1;
   assign w_limit   = (({1'b0, r_cycle_count} + 1'b1) == c_max);

   always_comb begin
      w_state_nxt   = r_state;
      w_rst_cnt_nxt = r_rst_cnt;
      w_cnt_nxt     = r_cycle_count;
      w_timeout_nxt = r_timeout;
      w_stalled_nxt = r_stalled;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt   = S_RESET;
               w_rst_cnt_nxt = c_rst_load;
               w_cnt_nxt     = '0;
               w_timeout_nxt = 1'b0;
               w_stalled_nxt = 1'b0;
            end
         end
         S_RESET: begin
            w_rst_cnt_nxt = r_rst_cnt - 1'b1;
            if (r_rst_cnt == 8'd1)
               w_state_nxt = S_RUN;
         end
         S_RUN: begin
            // The cycle that ends the run is still counted.
            w_cnt_nxt = w_cnt_inc;
            if (halt) begin
               w_state_nxt = S_DONE;
            end else if (w_stall) begin
               w_state_nxt   = S_DONE;
               w_stalled_nxt = 1'b1;
            end else if (w_limit) begin
               w_state_nxt   = S_DONE;
               w_timeout_nxt = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_rst_cnt     <= '0;
         r_cycle_count <= '0;
         r_proc_rst    <= 1'b1;
         r_running     <= 1'b0;
         r_done        <= 1'b0;
         r_timeout     <= 1'b0;
         r_stalled     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_rst_cnt     <= w_rst_cnt_nxt;
         r_cycle_count <= w_cnt_nxt;
         r_proc_rst    <= (w_state_nxt != S_RUN);
         r_running     <= (w_state_nxt == S_RUN);
         r_done        <= (w_state_nxt == S_DONE);
         r_timeout     <= w_timeout_nxt;
         r_stalled     <= w_stalled_nxt;
      end
   end

   assign proc_rst    = r_proc_rst;
   assign running     = r_running;
   assign done        = r_done;
   assign timeout     = r_timeout;
   assign stalled     = r_stalled;
   assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_proc_run_ctrl.sv
// ============================================================================
// Module   : tb_proc_run_ctrl
// Purpose  : Self-checking bench for proc_run_ctrl (RST_CYCLES=1 and =3 DUTs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_run_ctrl;

   logic        clk = 1'b0;
   logic        rst, start_a, start_b, halt;
   logic [31:0] pc;
   logic        proc_rst_a, running_a, done_a, timeout_a, stalled_a;
   logic        proc_rst_b, running_b, done_b, timeout_b, stalled_b;
   logic [15:0] cycle_count_a, cycle_count_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int halt_at;     // RUN cycle with halt=1 (0 = never)
      int stall_from;  // RUN cycle from which pc is frozen at 0x10 (0 = never)
      bit exp_to;
      bit exp_st;
      int exp_cnt;
   } vec_t;

   vec_t vecs[7];
   vec_t sbq[$];

   proc_run_ctrl #(.RST_CYCLES(1), .MAX_CYCLES(7), .CNT_W(16), .PC_W(32), .STALL_CYCLES(4)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .halt(halt), .pc(pc),
      .proc_rst(proc_rst_a), .running(running_a), .done(done_a),
      .timeout(timeout_a), .stalled(stalled_a), .cycle_count(cycle_count_a)
   );

   proc_run_ctrl #(.RST_CYCLES(3), .MAX_CYCLES(7), .CNT_W(16), .PC_W(32), .STALL_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .halt(halt), .pc(pc),
      .proc_rst(proc_rst_b), .running(running_b), .done(done_b),
      .timeout(timeout_b), .stalled(stalled_b), .cycle_count(cycle_count_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Launch one run on dut_a and follow it to DONE, then compare with the
   // expectation queued at launch time.
   task automatic run_vec(input vec_t v);
      int   k    = 0;
      int   rc   = 0;
      bit   seen = 1'b0;
      vec_t e;
      @(negedge clk);
      start_a = 1'b1;
      sbq.push_back(v);
      @(negedge clk);
      start_a = 1'b0;
      for (int t = 0; t < 60; t++) begin
         if (done_a) begin
            seen = 1'b1;
            break;
         end
         if (running_a) begin
            k++;
            chk("run_proc_rst", proc_rst_a, 0);
            halt = (k == v.halt_at);
            pc   = (v.stall_from != 0 && k >= v.stall_from) ? 32'h10 : 32'h100 + 32'(k * 4);
         end else begin
            rc++;
            chk("reset_proc_rst", proc_rst_a, 1);
            if (rc == 1)
               chk("reset_clear", {timeout_a, stalled_a, cycle_count_a}, 0);
         end
         @(negedge clk);
      end
      halt = 1'b0;
      chk("done_seen", seen, 1);
      e = sbq.pop_front();
      chk("timeout", timeout_a, e.exp_to);
      chk("stalled", stalled_a, e.exp_st);
      chk("cycle_count", cycle_count_a, e.exp_cnt);
      chk("reset_cycles", rc, 1);
      chk("run_edges", k, e.exp_cnt);
      chk("done_running", running_a, 0);
      chk("done_proc_rst", proc_rst_a, 1);
   endtask

   initial begin
      int k, rc;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; halt = 1'b0; pc = '0;
      repeat (3) @(negedge clk);
      chk("rst_proc_rst", proc_rst_a, 1);
      chk("rst_flags", {running_a, done_a, timeout_a, stalled_a}, 0);
      chk("rst_count", cycle_count_a, 0);

      // rst dominates start
      start_a = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_over_start", {proc_rst_a, running_a}, 2'b10);
      start_a = 1'b0;
      rst     = 1'b0;

      vecs[0] = '{2, 0, 1'b0, 1'b0, 2};
      vecs[1] = '{0, 0, 1'b1, 1'b0, 7};
      vecs[2] = '{7, 0, 1'b0, 1'b0, 7};
      vecs[3] = '{1, 0, 1'b0, 1'b0, 1};
`ifdef RUN_CTRL_STALL_DET_EN
      vecs[4] = '{0, 2, 1'b0, 1'b1, 5};
      vecs[6] = '{0, 4, 1'b0, 1'b1, 7};
`else
      vecs[4] = '{0, 2, 1'b1, 1'b0, 7};
      vecs[6] = '{0, 4, 1'b1, 1'b0, 7};
`endif
      vecs[5] = '{5, 2, 1'b0, 1'b0, 5};
      for (int i = 0; i < 7; i++)
         run_vec(vecs[i]);

      // rst in RUN cycle 3
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      k = 0;
      for (int t = 0; t < 20; t++) begin
         if (running_a) begin
            k++;
            pc = pc + 32'd4;
            if (k == 3) begin
               rst = 1'b1;
               break;
            end
         end
         @(negedge clk);
      end
      chk("midrst_reached", k, 3);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_proc_rst", proc_rst_a, 1);
      chk("midrst_flags", {running_a, done_a, timeout_a, stalled_a}, 0);
      chk("midrst_count", cycle_count_a, 0);
      run_vec(vecs[0]);

      // dut_b: timeout, then restart from DONE with RST_CYCLES=3
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (done_b) break;
         pc = pc + 32'd4;
         @(negedge clk);
      end
      chk("b_done", done_b, 1);
      chk("b_timeout", timeout_b, 1);
      chk("b_count", cycle_count_b, 7);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      chk("b_restart_clear", {done_b, timeout_b, stalled_b, cycle_count_b}, 0);
      rc = 0;
      for (int t = 0; t < 20; t++) begin
         if (running_b) break;
         if (proc_rst_b) rc++;
         pc = pc + 32'd4;
         @(negedge clk);
      end
      chk("b_reset_cycles", rc, 3);
      chk("b_run_entry_count", cycle_count_b, 0);
      pc = pc + 32'd4;
      @(negedge clk);
      chk("b_first_count", cycle_count_b, 1);
      chk("b_running", {running_b, proc_rst_b}, 2'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
